// File: rtl/display_stream_pkg.sv
// Shared types and constants for the debug-display scan streamer.
package display_stream_pkg;

  typedef enum logic [2:0] {IDLE, REQ, WAIT, CAPT, EMIT, NEXT, FIN} state_t;

  localparam int LINE_LEN = 18;

  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/hex_nibble_ascii.sv
// 4-bit nibble to uppercase ASCII hex digit.
module hex_nibble_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 'A' - 10 = 0x37
  assign ascii = (nibble < 4'd10) ? 8'h30 + {4'b0, nibble} : 8'h37 + {4'b0, nibble};

endmodule

// File: rtl/display_scan_streamer.sv
// Sweeps display_number over a slot range and streams each populated slot
// as an 18-byte "NAME = HHHHHHHH\r\n" line on a valid/ready byte stream.
module display_scan_streamer
  import display_stream_pkg::*;
#(
  parameter logic [5:0] FIRST_NUM = 6'd1,
  parameter logic [5:0] LAST_NUM  = 6'd44,
  parameter int         RESP_LAT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [5:0]  display_number,
  input  logic        display_valid,
  input  logic [39:0] display_name,
  input  logic [31:0] display_value,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        done
);

  localparam int LW = $clog2(RESP_LAT);

  state_t        state, state_nx;
  logic [LW-1:0] lat_cnt;
  logic          cap_valid;
  logic [39:0]   cap_name;
  logic [31:0]   cap_value;
  logic [4:0]    idx;
  logic          lat_hit, last_byte;
  logic [3:0]    nib;
  logic [7:0]    hex_ch;

  assign lat_hit   = (lat_cnt == LW'(RESP_LAT - 1));
  assign last_byte = (idx == 5'(LINE_LEN - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    tx_valid = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nx = REQ;
      end
      REQ:  state_nx = WAIT;
      WAIT: if (lat_hit) state_nx = CAPT;
      CAPT: state_nx = cap_valid ? EMIT : NEXT;
      EMIT: begin
        tx_valid = 1'b1;
        if (tx_ready && last_byte) state_nx = NEXT;
      end
      NEXT: state_nx = (display_number == LAST_NUM) ? FIN : REQ;
      FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // display_number is loaded on the edge entering REQ, so that edge is the
  // 0th latency edge and the response is sampled RESP_LAT edges later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      display_number <= '0;
      lat_cnt        <= '0;
      cap_valid      <= 1'b0;
      cap_name       <= '0;
      cap_value      <= '0;
      idx            <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          display_number <= FIRST_NUM;
          lat_cnt        <= '0;
        end
        REQ:  lat_cnt <= lat_cnt + LW'(1);
        WAIT: begin
          if (lat_hit) begin
            cap_valid <= display_valid;
            cap_name  <= display_name;
            cap_value <= display_value;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        CAPT: idx <= '0;
        EMIT: if (tx_ready) idx <= idx + 5'd1;
        NEXT: if (display_number != LAST_NUM) begin
          display_number <= display_number + 6'd1;
          lat_cnt        <= '0;
        end
        default: ;
      endcase
    end
  end

  // Hex digits occupy byte indices 8..15, most significant nibble first.
  assign nib = 4'(cap_value >> {4'd15 - idx[3:0], 2'b00});

  hex_nibble_ascii u_hex (
    .nibble (nib),
    .ascii  (hex_ch)
  );

  always_comb begin
    tx_byte = '0;
    if (state == EMIT) begin
      if (idx < 5'd5)                    tx_byte = 8'(cap_name >> {3'd4 - idx[2:0], 3'b000});
      else if (idx == 5'd5 || idx == 5'd7) tx_byte = ASCII_SP;
      else if (idx == 5'd6)              tx_byte = ASCII_EQ;
      else if (idx < 5'd16)              tx_byte = hex_ch;
      else if (idx == 5'd16)             tx_byte = ASCII_CR;
      else                               tx_byte = ASCII_LF;
    end
  end

endmodule

// File: tb/tb_display_scan_streamer.sv
// Directed bench for display_scan_streamer with a table-driven slot responder.
module tb_display_scan_streamer;

  logic        clk = 1'b0;
  logic        rst, start, tx_ready;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic [7:0]  tx_byte;
  logic        tx_valid, busy, done;

  logic        valid_tab [64];
  logic [39:0] name_tab  [64];
  logic [31:0] value_tab [64];

  assign display_valid = valid_tab[display_number];
  assign display_name  = name_tab[display_number];
  assign display_value = value_tab[display_number];

  display_scan_streamer #(.FIRST_NUM(6'd1), .LAST_NUM(6'd44), .RESP_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .display_number(display_number), .display_valid(display_valid),
    .display_name(display_name), .display_value(display_value),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int valid_cyc = 0, done_cnt = 0, stab_bad = 0, step_bad = 0;
  int hold_cnt [64];
  logic [7:0] rx_q [$];
  logic [7:0] exp_q [$];
  logic       pend = 1'b0, prev_busy = 1'b0;
  logic [7:0] pend_byte = '0;
  logic [5:0] prev_dn = '0;

  // Passive observer: transfers, stalls, done pulses, per-slot busy cycles.
  always @(negedge clk) begin
    if (rst) begin
      pend      <= 1'b0;
      prev_busy <= 1'b0;
    end else begin
      if (pend && !(tx_valid === 1'b1 && tx_byte === pend_byte)) stab_bad <= stab_bad + 1;
      pend      <= tx_valid && !tx_ready;
      pend_byte <= tx_byte;
      if (tx_valid && tx_ready) rx_q.push_back(tx_byte);
      if (tx_valid) valid_cyc <= valid_cyc + 1;
      if (done) done_cnt <= done_cnt + 1;
      if (busy) begin
        hold_cnt[display_number] <= hold_cnt[display_number] + 1;
        if (prev_busy && display_number != prev_dn && display_number != prev_dn + 6'd1)
          step_bad <= step_bad + 1;
      end
      prev_busy <= busy;
      prev_dn   <= display_number;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      tick();
      if (done === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (tx_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(8'(s[i]));
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic chk_line(input string tag, input int base);
    logic [63:0] o;
    chk({tag, "_len"}, 64'(rx_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      o = (base + i < rx_q.size()) ? 64'(rx_q[base + i]) : 'x;
      chk($sformatf("%s_b%0d", tag, i), o, 64'(exp_q[i]));
    end
  endtask

  initial begin
    bit ok;
    int base, d0, v0, s0, st0, bad;
    int hold0 [64];

    for (int i = 0; i < 64; i++) begin
      valid_tab[i] = 1'b0;
      name_tab[i]  = '0;
      value_tab[i] = '0;
      hold_cnt[i]  = 0;
    end
    rst = 1'b1; start = 1'b0; tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dn", 64'(display_number), 0);
    chk("rst_tx_byte", 64'(tx_byte), 0);
    chk("rst_tx_valid", 64'(tx_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    rst = 1'b0;
    tick();

    // Two populated slots, sink always ready
    valid_tab[1] = 1'b1; name_tab[1] = "   PC"; value_tab[1] = 32'hBFC00000;
    valid_tab[2] = 1'b1; name_tab[2] = " INST"; value_tab[2] = 32'h3C1D0001;
    exp_q.delete();
    push_str("   PC = BFC00000");
    push_str(" INST = 3C1D0001");
    base = rx_q.size(); d0 = done_cnt;
    start_pulse();
    chk("t1_busy", 64'(busy), 1);
    wait_done(1000, 1'b0, ok);
    chk("t1_timeout", 64'(ok), 1);
    chk("t1_bytes_at_done", 64'(rx_q.size() - base), 36);
    tick();
    chk_line("t1", base);
    chk("t1_done_cnt", 64'(done_cnt - d0), 1);
    chk("t1_busy_end", 64'(busy), 0);

    // Empty sweep
    valid_tab[1] = 1'b0; valid_tab[2] = 1'b0;
    for (int i = 0; i < 64; i++) hold0[i] = hold_cnt[i];
    d0 = done_cnt; v0 = valid_cyc; s0 = step_bad;
    start_pulse();
    wait_done(1000, 1'b0, ok);
    chk("t2_timeout", 64'(ok), 1);
    chk("t2_last_dn", 64'(display_number), 44);
    tick();
    chk("t2_valid_cycles", 64'(valid_cyc - v0), 0);
    chk("t2_done_cnt", 64'(done_cnt - d0), 1);
    chk("t2_busy_end", 64'(busy), 0);
    chk("t2_dn_steps", 64'(step_bad - s0), 0);
    bad = 0;
    for (int k = 0; k < 64; k++)
      if (hold_cnt[k] - hold0[k] != ((k >= 1 && k <= 44) ? 4 : 0)) bad++;
    chk("t2_hold_slots_bad", 64'(bad), 0);

    // Slot 5 with a randomly stalling sink
    valid_tab[5] = 1'b1; name_tab[5] = "REG00"; value_tab[5] = 32'h0000ABCD;
    exp_q.delete();
    push_str("REG00 = 0000ABCD");
    base = rx_q.size(); st0 = stab_bad;
    start_pulse();
    wait_done(3000, 1'b1, ok);
    tx_ready = 1'b1;
    chk("t3_timeout", 64'(ok), 1);
    tick();
    chk_line("t3", base);
    chk("t3_stall_stable", 64'(stab_bad - st0), 0);

    // Responder value changes right after capture
    exp_q.delete();
    push_str("REG00 = 0000ABCD");
    base = rx_q.size();
    start_pulse();
    wait_valid(500, ok);
    chk("t4_valid_timeout", 64'(ok), 1);
    value_tab[5] = 32'h12345678;
    wait_done(1000, 1'b0, ok);
    chk("t4_timeout", 64'(ok), 1);
    tick();
    chk_line("t4", base);
    valid_tab[5] = 1'b0; value_tab[5] = 32'h0000ABCD;

    // Reset while byte 7 is pending, then a clean sweep
    valid_tab[1] = 1'b1; valid_tab[2] = 1'b1;
    tx_ready = 1'b0;
    base = rx_q.size();
    start_pulse();
    wait_valid(500, ok);
    chk("t5_valid_timeout", 64'(ok), 1);
    tx_ready = 1'b1;
    repeat (7) tick();
    tx_ready = 1'b0;
    chk("t5_pre_count", 64'(rx_q.size() - base), 7);
    chk("t5_byte7", 64'(tx_byte), 64'h20);
    chk("t5_byte7_valid", 64'(tx_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_tx_valid", 64'(tx_valid), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_dn", 64'(display_number), 0);
    tick();
    tick();
    rst = 1'b0;
    tx_ready = 1'b1;
    tick();
    exp_q.delete();
    push_str("   PC = BFC00000");
    push_str(" INST = 3C1D0001");
    base = rx_q.size(); d0 = done_cnt;
    start_pulse();
    chk("t5_first_dn", 64'(display_number), 1);
    wait_done(1000, 1'b0, ok);
    chk("t5_timeout", 64'(ok), 1);
    tick();
    chk_line("t5", base);
    chk("t5_done_cnt", 64'(done_cnt - d0), 1);

    // Extra start pulses mid-sweep and on the done cycle are ignored
    base = rx_q.size(); d0 = done_cnt;
    start_pulse();
    repeat (20) tick();
    start_pulse();
    wait_done(1000, 1'b0, ok);
    chk("t6_timeout", 64'(ok), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("t6_busy_after_fin_start", 64'(busy), 0);
    chk_line("t6", base);
    chk("t6_done_cnt", 64'(done_cnt - d0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
